// File: rtl/hist_eq_mapper_pkg.sv
// Shared constants, FSM state encoding and helpers for the
// histogram-equalization pixel remapper.
package hist_eq_mapper_pkg;

    localparam int WORD_W       = 128;
    localparam int ADDR_W       = 16;
    localparam int LUT_ENTRIES  = 256;
    localparam int LUT_WORDS    = 64;
    localparam int PIX_PER_WORD = 16;
    localparam int LUT_BITS     = LUT_ENTRIES * 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_LUT_RD = 3'd1;
    localparam state_t S_PIX    = 3'd2;
    localparam state_t S_DRAIN  = 3'd3;
    localparam state_t S_DONE   = 3'd4;

    // Clamp a 32-bit table value to the 8-bit pixel range.
    function automatic logic [7:0] sat8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/hist_eq_mapper_lane_map.sv
// Combinational 16-lane table lookup: each input byte indexes
// the flattened 256x8 table and the result lands in the same lane.
module eq_lut_lane_map
    import hist_eq_mapper_pkg::*;
(
    input  logic [WORD_W-1:0]   pix_in,
    input  logic [LUT_BITS-1:0] lut,
    output logic [WORD_W-1:0]   pix_out
);

    for (genvar p = 0; p < PIX_PER_WORD; p++) begin : g_lane
        assign pix_out[8*p +: 8] = lut[{pix_in[8*p +: 8], 3'b000} +: 8];
    end

endmodule

// File: rtl/hist_eq_mapper.sv
// Histogram-equalization remapper: loads the 256-entry table from
// scratch memory, then streams pixel words through it into image memory.
module hist_eq_mapper
    import hist_eq_mapper_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LUT_BASE  = 16'h0000,
    parameter logic [ADDR_W-1:0] IN_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0] OUT_BASE  = 16'h1000,
    parameter logic [ADDR_W-1:0] PIX_WORDS = 16'd4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              map_en,
    output logic [ADDR_W-1:0] sc_mem_rd_addr1,
    output logic [ADDR_W-1:0] sc_mem_rd_addr2,
    input  logic [WORD_W-1:0] sc_mem_rd_data1,
    input  logic [WORD_W-1:0] sc_mem_rd_data2,
    output logic [ADDR_W-1:0] img_rd_addr,
    input  logic [WORD_W-1:0] img_rd_data,
    output logic [ADDR_W-1:0] img_wt_addr,
    output logic [WORD_W-1:0] img_wt_data,
    output logic              img_wt_en,
    output logic              lut_load_done,
    output logic              map_done
);

    state_t              state;
    logic [4:0]          pair_i;
    logic [ADDR_W-1:0]   word_j;

    logic                cap_v;
    logic [4:0]          cap_i;
    logic                rd_v;
    logic [ADDR_W-1:0]   rd_j;
    logic                wt_v;
    logic [ADDR_W-1:0]   wt_addr;
    logic [WORD_W-1:0]   wt_data;
    logic                lut_valid;
    logic [LUT_BITS-1:0] lut;

    logic                en_q;
    logic [WORD_W-1:0]   sc_hold1;
    logic [WORD_W-1:0]   sc_hold2;
    logic [WORD_W-1:0]   img_hold;
    logic [WORD_W-1:0]   sc_d1;
    logic [WORD_W-1:0]   sc_d2;
    logic [WORD_W-1:0]   img_d;
    logic [WORD_W-1:0]   mapped;

    logic                lut_last;

    assign lut_last = cap_v && (cap_i == 5'd31);

    // Memories keep answering while we are frozen, so their output may
    // already belong to the next address; keep the reply to the last
    // address issued in an enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= enable;
        end
        if (en_q) begin
            sc_hold1 <= sc_mem_rd_data1;
            sc_hold2 <= sc_mem_rd_data2;
            img_hold <= img_rd_data;
        end
    end

    assign sc_d1 = en_q ? sc_mem_rd_data1 : sc_hold1;
    assign sc_d2 = en_q ? sc_mem_rd_data2 : sc_hold2;
    assign img_d = en_q ? img_rd_data     : img_hold;

    // Sequencer: table load, pixel stream, drain, one-cycle done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            pair_i <= '0;
            word_j <= '0;
        end else if (enable) begin
            case (state)
                S_IDLE: begin
                    if (map_en) begin
                        state  <= S_LUT_RD;
                        pair_i <= '0;
                    end
                end
                S_LUT_RD: begin
                    if (pair_i == 5'd31) begin
                        state  <= S_PIX;
                        pair_i <= '0;
                        word_j <= '0;
                    end else begin
                        pair_i <= pair_i + 5'd1;
                    end
                end
                S_PIX: begin
                    if (word_j == PIX_WORDS - 16'd1) begin
                        state  <= S_DRAIN;
                        word_j <= '0;
                    end else begin
                        word_j <= word_j + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (!rd_v) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read-return tracking and the registered write stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_v     <= 1'b0;
            cap_i     <= '0;
            rd_v      <= 1'b0;
            rd_j      <= '0;
            wt_v      <= 1'b0;
            wt_addr   <= '0;
            wt_data   <= '0;
            lut_valid <= 1'b0;
        end else if (enable) begin
            cap_v <= (state == S_LUT_RD);
            cap_i <= pair_i;
            rd_v  <= (state == S_PIX);
            rd_j  <= word_j;
            wt_v  <= rd_v && lut_valid;
            if (rd_v) begin
                wt_addr <= OUT_BASE + rd_j;
                wt_data <= mapped;
            end
            if (state == S_IDLE && map_en) begin
                lut_valid <= 1'b0;
            end else if (lut_last) begin
                lut_valid <= 1'b1;
            end
        end
    end

    // Table capture: port 1 fills entries 8i..8i+3, port 2 the next four.
    always_ff @(posedge clk) begin
        if (!reset && enable && cap_v) begin
            for (int k = 0; k < 4; k++) begin
                lut[{cap_i, 3'(k), 3'b000} +: 8]     <= sat8(sc_d1[32*k +: 32]);
                lut[{cap_i, 3'(k + 4), 3'b000} +: 8] <= sat8(sc_d2[32*k +: 32]);
            end
        end
    end

    eq_lut_lane_map u_map (
        .pix_in  (img_d),
        .lut     (lut),
        .pix_out (mapped)
    );

    assign sc_mem_rd_addr1 = (state == S_LUT_RD) ?
                             LUT_BASE + {10'd0, pair_i, 1'b0} : '0;
    assign sc_mem_rd_addr2 = (state == S_LUT_RD) ?
                             LUT_BASE + {10'd0, pair_i, 1'b1} : '0;
    assign img_rd_addr     = (state == S_PIX) ? IN_BASE + word_j : '0;
    assign img_wt_addr     = wt_addr;
    assign img_wt_data     = wt_data;
    assign img_wt_en       = wt_v && enable;
    assign lut_load_done   = lut_last && enable;
    assign map_done        = (state == S_DONE) && enable;

endmodule

// File: tb/tb_hist_eq_mapper.sv
// Self-checking bench for hist_eq_mapper: randomized tables, images
// and clock-enable stalls against a cycle-timeline reference model.
module tb_hist_eq_mapper;

    localparam int N = 16;
    localparam logic [15:0] OUT_B = 16'h1000;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         map_en;
    logic [15:0]  sc_mem_rd_addr1;
    logic [15:0]  sc_mem_rd_addr2;
    logic [127:0] sc_mem_rd_data1;
    logic [127:0] sc_mem_rd_data2;
    logic [15:0]  img_rd_addr;
    logic [127:0] img_rd_data;
    logic [15:0]  img_wt_addr;
    logic [127:0] img_wt_data;
    logic         img_wt_en;
    logic         lut_load_done;
    logic         map_done;

    hist_eq_mapper #(
        .LUT_BASE  (16'h0000),
        .IN_BASE   (16'h0000),
        .OUT_BASE  (OUT_B),
        .PIX_WORDS (16'(N))
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .map_en          (map_en),
        .sc_mem_rd_addr1 (sc_mem_rd_addr1),
        .sc_mem_rd_addr2 (sc_mem_rd_addr2),
        .sc_mem_rd_data1 (sc_mem_rd_data1),
        .sc_mem_rd_data2 (sc_mem_rd_data2),
        .img_rd_addr     (img_rd_addr),
        .img_rd_data     (img_rd_data),
        .img_wt_addr     (img_wt_addr),
        .img_wt_data     (img_wt_data),
        .img_wt_en       (img_wt_en),
        .lut_load_done   (lut_load_done),
        .map_done        (map_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0]  lut_vals [256];
    logic [127:0] img_in   [N];
    logic [127:0] out_mem  [N];

    bit armed = 0;
    bit running = 0;
    bit just_rst = 0;
    int v = 0;
    int cyc = 0;
    int c0 = 0;
    int runs = 0;
    int wr_cnt = 0;
    int lld_rel = -1;
    int done_rel = -1;
    int done_cyc = 0;
    bit done_seen = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] exp_word(input logic [127:0] w);
        logic [127:0] r;
        logic [31:0]  val;
        r = '0;
        for (int p = 0; p < 16; p++) begin
            val = lut_vals[w[8*p +: 8]];
            r[8*p +: 8] = (val > 32'd255) ? 8'hFF : val[7:0];
        end
        return r;
    endfunction

    // Memories: registered read, one cycle of latency.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            sc_mem_rd_data1[32*k +: 32] <= lut_vals[{sc_mem_rd_addr1[5:0], 2'(k)}];
            sc_mem_rd_data2[32*k +: 32] <= lut_vals[{sc_mem_rd_addr2[5:0], 2'(k)}];
        end
        if (img_rd_addr < 16'(N))
            img_rd_data <= img_in[img_rd_addr[3:0]];
        else
            img_rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Reference timeline: v is the stall-free cycle index since C0.
    always @(posedge clk) begin
        if (reset) begin
            running  = 0;
            just_rst = 1;
            armed    = 1;
        end else if (enable) begin
            just_rst = 0;
            if (!running) begin
                if (map_en) begin
                    running = 1;
                    v       = 1;
                    c0      = cyc;
                    runs++;
                    wr_cnt  = 0;
                end
            end else if (v == 35 + N) begin
                running = 0;
            end else begin
                v++;
            end
        end
        cyc++;
    end

    // Compare every cycle against the timeline model.
    always @(negedge clk) begin
        logic [15:0] ea1, ea2, er;
        logic        ew, el, ed;
        int          j;
        if (armed) begin
            ea1 = 16'd0;
            ea2 = 16'd0;
            er  = 16'd0;
            ew  = 1'b0;
            el  = 1'b0;
            ed  = 1'b0;
            if (running) begin
                if (v >= 1 && v <= 32) begin
                    ea1 = 16'(2 * (v - 1));
                    ea2 = 16'(2 * (v - 1) + 1);
                end
                if (v >= 33 && v <= 32 + N) er = 16'(v - 33);
                ew = enable && (v >= 35) && (v <= 34 + N);
                el = enable && (v == 33);
                ed = enable && (v == 35 + N);
            end
            chk("sc_addr1", sc_mem_rd_addr1, ea1);
            chk("sc_addr2", sc_mem_rd_addr2, ea2);
            chk("img_rd_addr", img_rd_addr, er);
            chk("img_wt_en", img_wt_en, ew);
            chk("lut_load_done", lut_load_done, el);
            chk("map_done", map_done, ed);
            if (running && v >= 35 && v <= 34 + N) begin
                j = v - 35;
                chk("img_wt_addr", img_wt_addr, OUT_B + 16'(j));
                chk("img_wt_data", img_wt_data, exp_word(img_in[j]));
            end
            if (just_rst) begin
                chk("rst_wt_addr", img_wt_addr, 0);
                chk("rst_wt_data", img_wt_data, 0);
            end
            if (img_wt_en) begin
                wr_cnt++;
                if (img_wt_addr - OUT_B < 16'(N))
                    out_mem[4'(img_wt_addr - OUT_B)] = img_wt_data;
            end
            if (lut_load_done) lld_rel = cyc - c0;
            if (map_done) begin
                done_rel  = cyc - c0;
                done_cyc  = cyc;
                done_seen = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_v(input int t);
        int b = 0;
        while (!(running && v == t) && b < 300) begin
            tick();
            b++;
        end
        if (b >= 300) chk("wait_v_timeout", 0, 1);
    endtask

    task automatic wait_done(input int budget);
        int b = 0;
        while (!done_seen && b < budget) begin
            tick();
            b++;
        end
        chk("done_timeout", done_seen, 1);
    endtask

    task automatic start_run();
        done_seen = 0;
        lld_rel   = -1;
        done_rel  = -1;
        map_en    = 1;
        tick();
        map_en    = 0;
    endtask

    task automatic rand_tables();
        for (int e = 0; e < 256; e++)
            lut_vals[e] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
        for (int j = 0; j < N; j++)
            img_in[j] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int r;
        int b;
        reset  = 1;
        enable = 1;
        map_en = 0;
        for (int e = 0; e < 256; e++) lut_vals[e] = 32'(e);
        for (int j = 0; j < N; j++)
            for (int p = 0; p < 16; p++) img_in[j][8*p +: 8] = 8'(16 * j + p);
        repeat (3) tick();
        reset = 0;
        tick();

        // Identity table, busy pulses at C10 and C50 ignored.
        r = runs;
        start_run();
        wait_v(10);
        map_en = 1;
        tick();
        map_en = 0;
        wait_v(50);
        map_en = 1;
        tick();
        map_en = 0;
        wait_done(200);
        repeat (4) tick();
        chk("busy_one_run", runs - r, 1);
        chk("ident_lld_cycle", lld_rel, 33);
        chk("ident_done_cycle", done_rel, 35 + N);
        chk("ident_writes", wr_cnt, N);
        chk("ident_word0", out_mem[0], 128'h0F0E0D0C0B0A09080706050403020100);
        chk("ident_word3", out_mem[3], img_in[3]);

        // Saturation, with map_en held through DONE for a back-to-back run.
        for (int e = 0; e < 256; e++) lut_vals[e] = 32'(e);
        lut_vals[5] = 32'd300;
        lut_vals[7] = 32'hFFFF_FFFF;
        for (int j = 0; j < N; j++) img_in[j] = {$urandom, $urandom, $urandom, $urandom};
        img_in[0][23:0] = 24'h070605;
        done_seen = 0;
        map_en = 1;
        tick();
        wait_done(200);
        r = runs;
        b = 0;
        while (runs == r && b < 10) begin
            tick();
            b++;
        end
        map_en = 0;
        chk("restart_gap", c0 + 1 - done_cyc, 2);
        done_seen = 0;
        wait_done(200);
        chk("sat_byte05", out_mem[0][7:0], 8'hFF);
        chk("sat_byte06", out_mem[0][15:8], 8'h06);
        chk("sat_byte07", out_mem[0][23:16], 8'hFF);
        repeat (3) tick();

        // Reversed table.
        for (int e = 0; e < 256; e++) lut_vals[e] = 32'(255 - e);
        img_in[0] = 128'h0F0E0D0C0B0A09080706050403020100;
        start_run();
        wait_done(200);
        chk("order_word0", out_mem[0], 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        repeat (2) tick();

        // Three-cycle stall at C40.
        rand_tables();
        start_run();
        wait_v(40);
        enable = 0;
        repeat (3) tick();
        enable = 1;
        wait_done(200);
        chk("stall_done_cycle", done_rel, 54);
        chk("stall_writes", wr_cnt, 16);
        repeat (2) tick();

        // Reset at C20, then a full reload with a new table.
        start_run();
        wait_v(20);
        reset = 1;
        tick();
        reset = 0;
        repeat (3) tick();
        rand_tables();
        start_run();
        wait_done(200);
        chk("reload_lld_cycle", lld_rel, 33);
        chk("reload_done_cycle", done_rel, 35 + N);
        chk("reload_writes", wr_cnt, N);
        repeat (2) tick();

        // Random tables, images, enable drops and stray start pulses.
        for (int k = 0; k < 4; k++) begin
            rand_tables();
            start_run();
            b = 0;
            while (!done_seen && b < 400) begin
                enable = ($urandom_range(0, 5) != 0);
                map_en = running && (v < 30 + N) && ($urandom_range(0, 7) == 0);
                tick();
                b++;
            end
            enable = 1;
            map_en = 0;
            chk("rand_done", done_seen, 1);
            chk("rand_writes", wr_cnt, N);
            repeat (3) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
